// File: rtl/fir_lut_loader.sv
// rtl/fir_lut_loader.sv - coefficient load and DA partial-sum LUT generator for fir_filter
module fir_lut_loader #(
  parameter int NTAPS  = 64,
  parameter int NBANK  = 8,
  parameter int COEF_W = 16,
  parameter int LUT_W  = 19,
  parameter int ADDR_W = 11
) (
  input  logic                     clk_slow,
  input  logic                     resetn,
  input  logic                     start,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  output logic signed [LUT_W-1:0]  CIN,
  output logic [ADDR_W-1:0]        CADDR,
  output logic                     CLOAD,
  output logic                     busy,
  output logic                     done,
  output logic                     lut_valid
);

  localparam int TAP_W  = $clog2(NTAPS);
  localparam int BANK_W = $clog2(NBANK);

  typedef enum logic [1:0] {IDLE, COLLECT, GEN, FIN} state_t;

  state_t                    state;
  logic signed [COEF_W-1:0]  coef [NTAPS];
  logic [TAP_W-1:0]          tap_cnt;
  logic [BANK_W-1:0]         bank;
  logic [BANK_W-1:0]         bank_inc;
  logic [7:0]                n;
  logic signed [LUT_W-1:0]   acc;

  logic [7:0]                n_inc;
  logic [7:0]                g_next;
  logic [2:0]                flip;
  logic [COEF_W-1:0]         coef_sel;
  logic signed [LUT_W-1:0]   coef_ext;
  logic signed [LUT_W-1:0]   acc_next;

  // Gray walk: exactly one tap enters or leaves the sum per step, so one add/sub per entry.
  always_comb begin
    n_inc    = n + 8'd1;
    g_next   = n_inc ^ (n_inc >> 1);
    flip     = '0;
    for (int i = 7; i >= 0; i--) begin
      if (n_inc[i]) flip = 3'(i);
    end
    coef_sel = coef[{bank, flip}];
    coef_ext = {{(LUT_W-COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
    acc_next = g_next[flip] ? acc + coef_ext : acc - coef_ext;
    bank_inc = bank + BANK_W'(1);
  end

  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      bank       <= '0;
      n          <= '0;
      acc        <= '0;
      coef_ready <= 1'b0;
      CIN        <= '0;
      CADDR      <= '0;
      CLOAD      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lut_valid  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COLLECT;
            coef_ready <= 1'b1;
            busy       <= 1'b1;
            lut_valid  <= 1'b0;
            tap_cnt    <= '0;
          end
        end
        COLLECT: begin
          if (coef_valid && coef_ready) begin
            coef[tap_cnt] <= coef_in;
            tap_cnt       <= tap_cnt + TAP_W'(1);
            if (tap_cnt == TAP_W'(NTAPS - 1)) begin
              // Entry 0 of bank 0 is always zero, so it goes out on the same edge.
              state      <= GEN;
              coef_ready <= 1'b0;
              bank       <= '0;
              n          <= '0;
              acc        <= '0;
              CIN        <= '0;
              CADDR      <= '0;
              CLOAD      <= 1'b1;
            end
          end
        end
        GEN: begin
          if (n == 8'hFF) begin
            if (bank == BANK_W'(NBANK - 1)) begin
              state     <= FIN;
              CLOAD     <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              lut_valid <= 1'b1;
            end else begin
              bank  <= bank_inc;
              n     <= '0;
              acc   <= '0;
              CIN   <= '0;
              CADDR <= {bank_inc, 8'h00};
            end
          end else begin
            n     <= n_inc;
            acc   <= acc_next;
            CIN   <= acc_next;
            CADDR <= {bank, g_next};
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
